dp_ram_be: RTL and testbench



---
 rtl/dp_ram_pkg.sv | 16 +
 rtl/dp_ram_port_out.sv | 59 +++++
 rtl/dp_ram_be.sv | 142 ++++++++++++++
 tb/tb_dp_ram_be.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_ram_pkg.sv
// rtl/dp_ram_pkg.sv - shared types, constants and helpers for dp_ram_be
package dp_ram_pkg;

    typedef enum logic {
        READ_FIRST  = 1'b0,
        WRITE_FIRST = 1'b1
    } read_mode_e;

    localparam int CNT_W = 16;

    // Address width for a given depth; a single-word RAM still needs one bit.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dp_ram_port_out.sv
// rtl/dp_ram_port_out.sv - per-port read data / valid pipeline with optional output register
module dp_ram_port_out
    import dp_ram_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int OUT_REG = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_req,
    input  logic             in_range,
    input  logic [WIDTH-1:0] rd_word,
    output logic [WIDTH-1:0] data_out,
    output logic             valid
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;

    // First stage: capture the read word (zero for out-of-range) and hold it between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_req;
            if (rd_req) begin
                s1_data <= in_range ? rd_word : '0;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic             s2_valid;
            logic [WIDTH-1:0] s2_data;

            // Second stage: delay by one more cycle; reset drops any read still in flight
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign data_out = s2_data;
            assign valid    = s2_valid;
        end else begin : g_out_direct
            assign data_out = s1_data;
            assign valid    = s1_valid;
        end
    endgenerate

endmodule

// File: rtl/dp_ram_be.sv
// rtl/dp_ram_be.sv - true dual-port RAM with byte enables, read-during-write mode and collision counter
module dp_ram_be
    import dp_ram_pkg::*;
#(
    parameter  int DEPTH     = 8,
    parameter  int WIDTH     = 16,
    parameter  int READ_MODE = 0,
    parameter  int OUT_REG   = 0,
    localparam int ADDR_W    = addr_w(DEPTH),
    localparam int BE_W      = WIDTH / 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              en_a,
    input  logic              w_en_a,
    input  logic [BE_W-1:0]   be_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [WIDTH-1:0]  data_in_a,
    output logic [WIDTH-1:0]  data_out_a,
    output logic              valid_a,

    input  logic              en_b,
    input  logic              w_en_b,
    input  logic [BE_W-1:0]   be_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [WIDTH-1:0]  data_in_b,
    output logic [WIDTH-1:0]  data_out_b,
    output logic              valid_b,

    output logic              collision,
    output logic [CNT_W-1:0]  collision_cnt
);

    localparam bit WR_FIRST = (READ_MODE == int'(WRITE_FIRST));
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] mem [DEPTH];

    logic             in_range_a, in_range_b;
    logic             wr_a, wr_b, rd_a, rd_b;
    logic             same_addr, coll_now;
    logic [WIDTH-1:0] cur_a, cur_b;
    logic [WIDTH-1:0] merged_a, merged_b;
    logic [WIDTH-1:0] rd_word_a, rd_word_b;

    assign in_range_a = 32'(addr_a) < 32'(DEPTH);
    assign in_range_b = 32'(addr_b) < 32'(DEPTH);

    // Out-of-range writes are dropped here so they never touch memory or count as collisions
    assign wr_a = en_a & w_en_a & in_range_a;
    assign wr_b = en_b & w_en_b & in_range_b;
    assign rd_a = en_a & ~w_en_a;
    assign rd_b = en_b & ~w_en_b;

    assign same_addr = (addr_a == addr_b);
    assign coll_now  = wr_a & wr_b & same_addr & (|(be_a & be_b));

    // Byte-lane writes; port A is applied last so it owns any byte both ports enable
    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (wr_b && be_b[i]) begin
                mem[addr_b][8*i +: 8] <= data_in_b[8*i +: 8];
            end
            if (wr_a && be_a[i]) begin
                mem[addr_a][8*i +: 8] <= data_in_a[8*i +: 8];
            end
        end
    end

    assign cur_a = mem[addr_a];
    assign cur_b = mem[addr_b];

    // Word at addr_a as it will look after this edge's writes (A wins over B per byte)
    always_comb begin
        merged_a = cur_a;
        for (int i = 0; i < BE_W; i++) begin
            if (wr_b && same_addr && be_b[i]) begin
                merged_a[8*i +: 8] = data_in_b[8*i +: 8];
            end
            if (wr_a && be_a[i]) begin
                merged_a[8*i +: 8] = data_in_a[8*i +: 8];
            end
        end
    end

    // Word at addr_b as it will look after this edge's writes (A wins over B per byte)
    always_comb begin
        merged_b = cur_b;
        for (int i = 0; i < BE_W; i++) begin
            if (wr_b && be_b[i]) begin
                merged_b[8*i +: 8] = data_in_b[8*i +: 8];
            end
            if (wr_a && same_addr && be_a[i]) begin
                merged_b[8*i +: 8] = data_in_a[8*i +: 8];
            end
        end
    end

    assign rd_word_a = WR_FIRST ? merged_a : cur_a;
    assign rd_word_b = WR_FIRST ? merged_b : cur_b;

    dp_ram_port_out #(
        .WIDTH   (WIDTH),
        .OUT_REG (OUT_REG)
    ) u_port_out_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_req   (rd_a),
        .in_range (in_range_a),
        .rd_word  (rd_word_a),
        .data_out (data_out_a),
        .valid    (valid_a)
    );

    dp_ram_port_out #(
        .WIDTH   (WIDTH),
        .OUT_REG (OUT_REG)
    ) u_port_out_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_req   (rd_b),
        .in_range (in_range_b),
        .rd_word  (rd_word_b),
        .data_out (data_out_b),
        .valid    (valid_b)
    );

    // Collision pulse and saturating counter, both updated on the colliding edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            collision     <= 1'b0;
            collision_cnt <= '0;
        end else begin
            collision <= coll_now;
            if (coll_now && (collision_cnt != CNT_MAX)) begin
                collision_cnt <= collision_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dp_ram_be.sv
// tb/tb_dp_ram_be.sv - self-checking bench for dp_ram_be in two configurations
module tb_dp_ram_be;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic        en_a = 1'b0, w_en_a = 1'b0, en_b = 1'b0, w_en_b = 1'b0;
    logic [1:0]  be_a = '0, be_b = '0;
    logic [2:0]  addr_a = '0, addr_b = '0;
    logic [15:0] data_in_a = '0, data_in_b = '0;

    logic [1:0][15:0] data_out_a, data_out_b, collision_cnt;
    logic [1:0]       valid_a, valid_b, collision;

    int tests = 0;
    int fails = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    // instance 0: DEPTH 8, read-first, no output register
    dp_ram_be #(.DEPTH(8), .WIDTH(16), .READ_MODE(0), .OUT_REG(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .w_en_a(w_en_a), .be_a(be_a), .addr_a(addr_a), .data_in_a(data_in_a),
        .data_out_a(data_out_a[0]), .valid_a(valid_a[0]),
        .en_b(en_b), .w_en_b(w_en_b), .be_b(be_b), .addr_b(addr_b), .data_in_b(data_in_b),
        .data_out_b(data_out_b[0]), .valid_b(valid_b[0]),
        .collision(collision[0]), .collision_cnt(collision_cnt[0])
    );

    // instance 1: DEPTH 6, write-first, output register
    dp_ram_be #(.DEPTH(6), .WIDTH(16), .READ_MODE(1), .OUT_REG(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .en_a(en_a), .w_en_a(w_en_a), .be_a(be_a), .addr_a(addr_a), .data_in_a(data_in_a),
        .data_out_a(data_out_a[1]), .valid_a(valid_a[1]),
        .en_b(en_b), .w_en_b(w_en_b), .be_b(be_b), .addr_b(addr_b), .data_in_b(data_in_b),
        .data_out_b(data_out_b[1]), .valid_b(valid_b[1]),
        .collision(collision[1]), .collision_cnt(collision_cnt[1])
    );

    // ---------------- behavioural model ----------------
    logic [15:0] mm [2][8];
    bit          hv [2][2][4];
    logic [15:0] hd [2][2][4];
    bit          ev [2][2];
    logic [15:0] ed [2][2];
    bit          ec [2];
    int          ecnt [2];
    int          cyc = 0;

    function automatic int dep(int k);
        return (k == 0) ? 8 : 6;
    endfunction

    function automatic int lat(int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic bit write_first(int k);
        return k == 1;
    endfunction

    function automatic bit writes(int k, int p);
        if (p == 0) return en_a && w_en_a && int'(addr_a) < dep(k);
        return en_b && w_en_b && int'(addr_b) < dep(k);
    endfunction

    function automatic bit reads(int p);
        return (p == 0) ? (en_a && !w_en_a) : (en_b && !w_en_b);
    endfunction

    // Contents of word ad once this cycle's writes land: A byte, else B byte, else old byte
    function automatic logic [15:0] after_word(int k, logic [2:0] ad);
        logic [15:0] w;
        w = mm[k][ad];
        for (int i = 0; i < 2; i++) begin
            if (writes(k, 0) && addr_a == ad && be_a[i]) w[8*i +: 8] = data_in_a[8*i +: 8];
            else if (writes(k, 1) && addr_b == ad && be_b[i]) w[8*i +: 8] = data_in_b[8*i +: 8];
        end
        return w;
    endfunction

    function automatic logic [15:0] read_val(int k, int p);
        logic [2:0] ad;
        ad = (p == 0) ? addr_a : addr_b;
        if (int'(ad) >= dep(k)) return 16'h0000;
        return write_first(k) ? after_word(k, ad) : mm[k][ad];
    endfunction

    function automatic bit collides(int k);
        return writes(k, 0) && writes(k, 1) && addr_a == addr_b && (|(be_a & be_b));
    endfunction

    logic [15:0] m_rv [2];
    bit          m_rq [2];
    logic [15:0] m_wa, m_wb;
    bit          m_cn;
    int          m_slot, m_src;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                ec[k]   = 1'b0;
                ecnt[k] = 0;
                for (int p = 0; p < 2; p++) begin
                    ev[k][p] = 1'b0;
                    ed[k][p] = 16'h0000;
                    for (int s = 0; s < 4; s++) hv[k][p][s] = 1'b0;
                end
            end
        end else begin
            m_slot = cyc % 4;
            for (int k = 0; k < 2; k++) begin
                m_cn = collides(k);
                for (int p = 0; p < 2; p++) begin
                    m_rq[p] = reads(p);
                    m_rv[p] = read_val(k, p);
                end
                m_wa = after_word(k, addr_a);
                m_wb = after_word(k, addr_b);
                if (writes(k, 0)) mm[k][addr_a] = m_wa;
                if (writes(k, 1)) mm[k][addr_b] = m_wb;
                ec[k] = m_cn;
                if (m_cn && ecnt[k] < 65535) ecnt[k] = ecnt[k] + 1;
                m_src = (cyc + 5 - lat(k)) % 4;
                for (int p = 0; p < 2; p++) begin
                    hv[k][p][m_slot] = m_rq[p];
                    hd[k][p][m_slot] = m_rv[p];
                    ev[k][p] = hv[k][p][m_src];
                    if (ev[k][p]) ed[k][p] = hd[k][p][m_src];
                end
            end
            cyc = cyc + 1;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("valid_a[%0d]", k), 32'(valid_a[k]), 32'(ev[k][0]));
                check($sformatf("valid_b[%0d]", k), 32'(valid_b[k]), 32'(ev[k][1]));
                check($sformatf("data_out_a[%0d]", k), 32'(data_out_a[k]), 32'(ed[k][0]));
                check($sformatf("data_out_b[%0d]", k), 32'(data_out_b[k]), 32'(ed[k][1]));
                check($sformatf("collision[%0d]", k), 32'(collision[k]), 32'(ec[k]));
                check($sformatf("collision_cnt[%0d]", k), 32'(collision_cnt[k]), 32'(ecnt[k]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drv(input bit ea, input bit wa, input logic [1:0] ba, input logic [2:0] aa,
                       input logic [15:0] da, input bit eb, input bit wb, input logic [1:0] bb,
                       input logic [2:0] ab, input logic [15:0] db);
        @(negedge clk);
        en_a = ea; w_en_a = wa; be_a = ba; addr_a = aa; data_in_a = da;
        en_b = eb; w_en_b = wb; be_b = bb; addr_b = ab; data_in_b = db;
    endtask

    task automatic idle();
        drv(0, 0, 2'b00, 3'd0, 16'h0, 0, 0, 2'b00, 3'd0, 16'h0);
    endtask

    task automatic wr_a(input logic [2:0] ad, input logic [15:0] d);
        drv(1, 1, 2'b11, ad, d, 0, 0, 2'b00, 3'd0, 16'h0);
    endtask

    task automatic rd_a(input logic [2:0] ad);
        drv(1, 0, 2'b00, ad, 16'h0, 0, 0, 2'b00, 3'd0, 16'h0);
    endtask

    task automatic rd_b(input logic [2:0] ad);
        drv(0, 0, 2'b00, 3'd0, 16'h0, 1, 0, 2'b00, ad, 16'h0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        chk_on = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("lit_reset_dout_a", 32'(data_out_a[k]), 32'h0);
            check("lit_reset_valid_b", 32'(valid_b[k]), 32'h0);
            check("lit_reset_cnt", 32'(collision_cnt[k]), 32'h0);
        end
        @(negedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 8; i++) wr_a(3'(i), 16'(16'h0101 * i));

        // write then read on the other port
        wr_a(3'd3, 16'hA5A5);
        rd_b(3'd3);
        idle();
        check("lit_t1_dout_b0", 32'(data_out_b[0]), 32'h0000A5A5);
        check("lit_t1_valid_b0", 32'(valid_b[0]), 32'h1);
        check("lit_t1_valid_b1_early", 32'(valid_b[1]), 32'h0);
        idle();
        check("lit_t1_dout_b1", 32'(data_out_b[1]), 32'h0000A5A5);
        check("lit_t1_valid_b1", 32'(valid_b[1]), 32'h1);

        // byte-merged write/write collision
        wr_a(3'd5, 16'h0000);
        drv(1, 1, 2'b10, 3'd5, 16'h1122, 1, 1, 2'b11, 3'd5, 16'h3344);
        idle();
        for (int k = 0; k < 2; k++) begin
            check("lit_t2_collision", 32'(collision[k]), 32'h1);
            check("lit_t2_cnt", 32'(collision_cnt[k]), 32'h1);
        end
        idle();
        check("lit_t2_collision_drop", 32'(collision[0]), 32'h0);
        rd_a(3'd5);
        idle();
        check("lit_t2_merge0", 32'(data_out_a[0]), 32'h00001144);
        idle();
        check("lit_t2_merge1", 32'(data_out_a[1]), 32'h00001144);

        // read-during-write on the same address
        wr_a(3'd2, 16'h00FF);
        drv(1, 1, 2'b11, 3'd2, 16'hBEEF, 1, 0, 2'b00, 3'd2, 16'h0);
        idle();
        check("lit_t3_read_first", 32'(data_out_b[0]), 32'h000000FF);
        idle();
        check("lit_t3_write_first", 32'(data_out_b[1]), 32'h0000BEEF);
        check("lit_t3_valid_b1", 32'(valid_b[1]), 32'h1);

        // out-of-range access (only for the DEPTH 6 instance)
        wr_a(3'd7, 16'h7777);
        rd_b(3'd7);
        idle();
        check("lit_t4_inrange", 32'(data_out_b[0]), 32'h00007777);
        idle();
        check("lit_t4_oor_data", 32'(data_out_b[1]), 32'h0);
        check("lit_t4_oor_valid", 32'(valid_b[1]), 32'h1);
        for (int i = 0; i < 6; i++) rd_a(3'(i));
        idle();
        idle();

        drv(1, 1, 2'b11, 3'd7, 16'h1111, 1, 1, 2'b11, 3'd7, 16'h2222);
        idle();
        check("lit_t4_oor_coll0", 32'(collision[0]), 32'h1);
        check("lit_t4_oor_coll1", 32'(collision[1]), 32'h0);
        check("lit_t4_cnt0", 32'(collision_cnt[0]), 32'h2);
        check("lit_t4_cnt1", 32'(collision_cnt[1]), 32'h1);
        drv(1, 1, 2'b00, 3'd1, 16'hFFFF, 1, 1, 2'b11, 3'd1, 16'h2222);
        idle();
        check("lit_t4_be0_coll", 32'(collision[0]), 32'h0);
        drv(1, 0, 2'b00, 3'd1, 16'h0, 1, 0, 2'b00, 3'd1, 16'h0);
        idle();
        check("lit_t4_rr_a0", 32'(data_out_a[0]), 32'h00002222);
        check("lit_t4_rr_b0", 32'(data_out_b[0]), 32'h00002222);
        check("lit_t4_rr_coll", 32'(collision[0]), 32'h0);
        idle();

        // reset with a read in flight
        rd_a(3'd3);
        idle();
        #1 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("lit_t5_async_dout", 32'(data_out_a[k]), 32'h0);
            check("lit_t5_async_cnt", 32'(collision_cnt[k]), 32'h0);
        end
        @(negedge clk);
        check("lit_t5_flush_valid", 32'(valid_a[1]), 32'h0);
        check("lit_t5_flush_dout", 32'(data_out_a[1]), 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        rd_a(3'd3);
        idle();
        idle();
        check("lit_t5_retained", 32'(data_out_a[1]), 32'h0000A5A5);
        rd_a(3'd5);
        idle();
        idle();

        // counter saturation
        repeat (65534) drv(1, 1, 2'b01, 3'd4, 16'h00AA, 1, 1, 2'b01, 3'd4, 16'h00BB);
        idle();
        check("lit_t6_cnt_fffe", 32'(collision_cnt[0]), 32'h0000FFFE);
        repeat (2) drv(1, 1, 2'b01, 3'd4, 16'h00AA, 1, 1, 2'b01, 3'd4, 16'h00BB);
        idle();
        check("lit_t6_cnt_ffff", 32'(collision_cnt[1]), 32'h0000FFFF);
        drv(1, 1, 2'b01, 3'd4, 16'h00AA, 1, 1, 2'b01, 3'd4, 16'h00BB);
        idle();
        check("lit_t6_sat_coll", 32'(collision[0]), 32'h1);
        check("lit_t6_sat_cnt", 32'(collision_cnt[0]), 32'h0000FFFF);
        rd_b(3'd4);
        idle();
        idle();
        check("lit_t6_merge", 32'(data_out_b[1]), 32'h000004AA);

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
